// File: rtl/fp32_mul_sequencer.sv
// fp32_mul_sequencer: operand-issue and result-capture stage around a start/done FP32
// multiplier core. Operand pairs enter through a DEPTH-entry FIFO. One pair at a time is
// issued to the multiplier, and each product is held on a valid/ready output stream.
// Optional build macro: FP32_MUL_SEQ_TAG_EN adds an 8-bit tag that travels with each pair.

module fp32_mul_sequencer #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  // operand stream
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
`ifdef FP32_MUL_SEQ_TAG_EN
  input  logic [7:0]       in_tag,
  output logic [7:0]       out_tag,
`endif
  // product stream
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  // multiplier core handshake
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic             mul_start,
  input  logic [31:0]      mul_result,
  input  logic             mul_done,
  // status
  output logic [CNT_W-1:0] count,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // FIFO storage and bookkeeping
  logic [31:0]      r_mem_a [DEPTH];
  logic [31:0]      r_mem_b [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Sequencer state and output registers
  logic [1:0]       r_state;
  logic [31:0]      r_mul_a;
  logic [31:0]      r_mul_b;
  logic             r_mul_start;
  logic             r_out_valid;
  logic [31:0]      r_out_result;

`ifdef FP32_MUL_SEQ_TAG_EN
  logic [7:0]       r_mem_t [DEPTH];
  logic [7:0]       r_mul_tag;
  logic [7:0]       r_out_tag;
`endif

  // Next-state and control strobes
  logic [1:0]       w_state_d;
  logic             w_push;
  logic             w_pop;
  logic             w_capture;
  logic             w_out_clr;
  logic             w_full;
  logic             w_nonempty;

  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_nonempty = (r_count != '0);
  assign w_push     = in_valid && !w_full;

  // Sequencer control: decides pops, product capture and output release
  always_comb begin
    w_state_d = r_state;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_out_clr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_nonempty) begin
          w_pop     = 1'b1;
          w_state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // Only place where the multiplier's done pulse is honoured
        if (mul_done) begin
          w_capture = 1'b1;
          w_state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (r_out_valid && out_ready) begin
          w_out_clr = 1'b1;
          // Pop straight into ISSUE so back-to-back products are 5 cycles apart
          if (w_nonempty) begin
            w_pop     = 1'b1;
            w_state_d = ST_ISSUE;
          end else begin
            w_state_d = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage write; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= in_a;
      r_mem_b[r_wr_ptr] <= in_b;
`ifdef FP32_MUL_SEQ_TAG_EN
      r_mem_t[r_wr_ptr] <= in_tag;
`endif
    end
  end

  // Multiplier operands: loaded only on a pop, so they stay put through ISSUE and WAIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_start <= 1'b0;
`ifdef FP32_MUL_SEQ_TAG_EN
      r_mul_tag   <= '0;
`endif
    end else begin
      // Every pop enters ISSUE, so the registered strobe is high for exactly that cycle
      r_mul_start <= w_pop;
      if (w_pop) begin
        r_mul_a   <= r_mem_a[r_rd_ptr];
        r_mul_b   <= r_mem_b[r_rd_ptr];
`ifdef FP32_MUL_SEQ_TAG_EN
        r_mul_tag <= r_mem_t[r_rd_ptr];
`endif
      end
    end
  end

  // Output register: capture on done in WAIT, hold until the consumer takes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
`ifdef FP32_MUL_SEQ_TAG_EN
      r_out_tag    <= '0;
`endif
    end else if (w_capture) begin
      r_out_valid  <= 1'b1;
      r_out_result <= mul_result;
`ifdef FP32_MUL_SEQ_TAG_EN
      r_out_tag    <= r_mul_tag;
`endif
    end else if (w_out_clr) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign in_ready   = !w_full;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign mul_start  = r_mul_start;
  assign count      = r_count;
  assign busy       = (r_state != ST_IDLE) || w_nonempty;
`ifdef FP32_MUL_SEQ_TAG_EN
  assign out_tag    = r_out_tag;
`endif

endmodule

// File: doc/fp32_mul_sequencer.md
# fp32_mul_sequencer

Operand-issue and result-capture stage wrapped around the fp32_multiplier start/done core. Accepts FP32 operand pairs on a valid/ready stream, buffers them in a DEPTH-entry FIFO, and issues one pair at a time to the multiplier. It holds the multiplier operands stable from start until done, then presents each product on a valid/ready output stream. It sits between the datapath operand source and any downstream FP consumer, such as an accumulator.

## Interface
- DEPTH, 4, operand FIFO entries; power of two, at least 2
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  operand pair offered
- in_ready  out  1  FIFO not full
- in_a  in  32  operand A, IEEE-754 single
- in_b  in  32  operand B, IEEE-754 single
- out_valid  out  1  product held in output register
- out_ready  in  1  consumer accepts product
- out_result  out  32  product, IEEE-754 single
- mul_a  out  32  registered operand A to multiplier
- mul_b  out  32  registered operand B to multiplier
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_result  in  32  multiplier result
- mul_done  in  1  multiplier completion pulse
- count  out  $clog2(DEPTH+1)  FIFO occupancy
- busy  out  1  state is not IDLE, or FIFO is non-empty

## Operation
- The FIFO push happens on any edge where in_valid && in_ready. The pop is internal and is performed by the FSM. Push and pop on the same edge leave count unchanged.
- in_ready = (count != DEPTH). Pushes are never accepted when full, so there is no overwrite.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Order is strictly FIFO.
- FSM states:
  - IDLE: if count != 0, pop the head into mul_a/mul_b and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: mul_start = 1 for exactly this cycle. Go to WAIT.
  - WAIT: on mul_done, load out_result <= mul_result, set out_valid <= 1 and go to HOLD.
  - HOLD: on out_valid && out_ready, clear out_valid. If count != 0, pop the next pair into mul_a/mul_b and go to ISSUE. Otherwise go to IDLE.
- mul_a and mul_b change only on a pop edge. They are stable across ISSUE and WAIT.
- mul_done is ignored in IDLE, ISSUE and HOLD.
- out_result and out_valid are stable while out_valid && !out_ready.
- Illegal state encodings go to IDLE on the next edge.
- Reset values: in_ready = 1, out_valid = 0, out_result = 0, mul_a = 0, mul_b = 0, mul_start = 0, count = 0, busy = 0, state IDLE. Pointers are cleared.
- Reset mid-operation discards all queued pairs and the in-flight product. The multiplier shares the same reset.

## Timing
- Cycle 0 is an accepting edge with the FIFO empty and the block in IDLE.
  - Cycle 1: pop.
  - Cycle 2: mul_start high.
  - Multiplier states: COMPUTE in cycle 3, FINISH in cycle 4, mul_done high in cycle 5.
  - Cycle 6: out_valid high.
- Input-to-output latency is 6 cycles.
- Back-to-back throughput is one product per 5 cycles when out_ready is held at 1. The HOLD exit pops directly into ISSUE.
- out_ready held low stalls issue. The FIFO continues to fill up to DEPTH.
- in_ready deasserts the cycle after the push that makes count equal DEPTH. It reasserts the cycle after the next pop.

## Configuration
- FP32_MUL_SEQ_TAG_EN, when defined:
  - adds in_tag (input, 8 bits) and out_tag (output, 8 bits);
  - the tag is stored per FIFO entry and captured alongside mul_a/mul_b at pop;
  - out_tag is driven with out_result; reset value is 0.
- When not defined, the tag ports, FIFO tag storage and tag register are absent. All other behaviour is identical.

## Test plan
- Single op: push a=0x40400000 (3.0), b=0x40000000 (2.0). Required: out_valid rises exactly 6 cycles later with out_result=0x40C00000, and mul_start is high for exactly one cycle.
- Burst of 4 with out_ready=1: push 1.0×1.0, 2.0×2.0, 0.5×4.0, −1.0×3.0 on consecutive cycles. Required: results 0x3F800000, 0x40800000, 0x40000000, 0xC0400000 in order, 5 cycles apart.
- Backpressure and full: hold out_ready=0 and push 6 pairs with DEPTH=4. Required: in_ready=0 once count=4, no pair is lost or duplicated, and the output holds stable. Release out_ready and all accepted products drain in order.
- Spurious done: pulse mul_done while in IDLE and while in HOLD. Required: no change to out_valid, out_result or state.
- Reset mid-operation: assert reset during WAIT with 2 pairs queued. Required: all outputs are at their reset values immediately, and no output appears after release until new pushes are made.
- With FP32_MUL_SEQ_TAG_EN: push tags 0x11, 0x22, 0x33. Required: out_tag follows 0x11, 0x22, 0x33, matched to the corresponding products.
